// File: rtl/sram_mem_controller.sv
// MEM-stage data port for a 16-bit asynchronous SRAM: each 32-bit access becomes
// two half-word accesses of WAIT_CYCLES clocks each, with ready low while in flight.
module sram_mem_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_LO   = 2'd1;
    localparam logic [1:0]  S_HI   = 2'd2;
    localparam logic [1:0]  S_DONE = 2'd3;
    localparam logic [3:0]  LAST   = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE   = 32'(BASE_ADDR);

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [SRAM_AW-2:0] idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               dq_oe_q, dq_oe_d;
    logic [15:0]        dq_q, dq_d;
    logic               req;
    logic               acc_d;

    assign req = wr_en | rd_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LO;
                    cnt_d   = 4'd0;
                    wr_d    = wr_en;
                    idx_d   = (SRAM_AW-1)'((address - BASE) >> 2);
                    wdata_d = write_data;
                end
            end
            S_LO, S_HI: begin
                if (cnt_q == LAST) begin
                    cnt_d   = 4'd0;
                    state_d = (state_q == S_LO) ? S_HI : S_DONE;
                    // Sample at the end of the half, after OE has been low the full window.
                    if (!wr_q) begin
                        if (state_q == S_LO) rdata_d[15:0]  = SRAM_DQ;
                        else                 rdata_d[31:16] = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin outputs are registered from next-state values so they are glitch-free.
        acc_d   = (state_d == S_LO) || (state_d == S_HI);
        addr_d  = addr_q;
        if (state_d == S_LO) addr_d = {idx_d, 1'b0};
        if (state_d == S_HI) addr_d = {idx_d, 1'b1};
        we_n_d  = !(acc_d && wr_d && (cnt_d != LAST));
        oe_n_d  = !(acc_d && !wr_d);
        dq_oe_d = acc_d && wr_d;
        dq_d    = (state_d == S_HI) ? wdata_d[31:16] : wdata_d[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            addr_q  <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            dq_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            dq_oe_q <= dq_oe_d;
            dq_q    <= dq_d;
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:  ready = ~req;
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_oe_q ? dq_q : 16'bz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign read_data = rdata_q;

endmodule
